// File: rtl/vx_commit_packetizer_if.sv
// Commit packetizer bus: the result handshake from the execution unit (in_*) and
// the framed beat stream towards the commit arbiter (commit_*).
// master: the packetizer's view. slave: the surrounding unit / arbiter view.
interface vx_commit_packetizer_if #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NW_WIDTH    = 2,
  parameter int unsigned NR_BITS     = 6,
  parameter int unsigned PC_BITS     = 30,
  parameter int unsigned UUID_WIDTH  = 44
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [UUID_WIDTH-1:0]       in_uuid;
  logic [NW_WIDTH-1:0]         in_wid;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [PC_BITS-1:0]          in_PC;
  logic                        in_wb;
  logic [NR_BITS-1:0]          in_rd;
  logic [NUM_THREADS*XLEN-1:0] in_data;

  logic                        commit_valid;
  logic                        commit_ready;
  logic [UUID_WIDTH-1:0]       commit_uuid;
  logic [NW_WIDTH-1:0]         commit_wid;
  logic [NUM_THREADS-1:0]      commit_tmask;
  logic [PC_BITS-1:0]          commit_PC;
  logic                        commit_wb;
  logic [NR_BITS-1:0]          commit_rd;
  logic [NUM_THREADS*XLEN-1:0] commit_data;
  logic                        commit_sop;
  logic                        commit_eop;

  modport master (
    input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_data,
    output in_ready,
    output commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC, commit_wb,
    output commit_rd, commit_data, commit_sop, commit_eop,
    input  commit_ready
  );

  modport slave (
    output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_wb, in_rd, in_data,
    input  in_ready,
    input  commit_valid, commit_uuid, commit_wid, commit_tmask, commit_PC, commit_wb,
    input  commit_rd, commit_data, commit_sop, commit_eop,
    output commit_ready
  );

endinterface

// File: rtl/vx_commit_packetizer.sv
// Commit packetizer: takes one full-warp result per handshake and emits one commit beat
// per active lane group, framed with sop/eop. An all-inactive warp still produces a
// single sop=eop beat so the scheduler sees the instruction complete.
// Optional: define VX_COMMIT_PACKETIZER_PERF_EN to add perf_beats / perf_stalls counters.
module vx_commit_packetizer #(
  parameter int unsigned NUM_THREADS   = 4,
  parameter int unsigned NUM_LANES     = 2,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NW_WIDTH      = 2,
  parameter int unsigned NR_BITS       = 6,
  parameter int unsigned PC_BITS       = 30,
  parameter int unsigned UUID_WIDTH    = 44
`ifdef VX_COMMIT_PACKETIZER_PERF_EN
  ,
  parameter int unsigned PERF_CTR_BITS = 32
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  vx_commit_packetizer_if.master   bus
`ifdef VX_COMMIT_PACKETIZER_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_beats,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  localparam int unsigned NG = NUM_THREADS / NUM_LANES;
  localparam int unsigned DW = NUM_THREADS * XLEN;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q;
  logic [NG-1:0]          pend_q;    // groups still to send, current group included
  logic                   valid_q;
  logic                   sop_q;
  logic                   eop_q;
  logic [UUID_WIDTH-1:0]  uuid_q;
  logic [NW_WIDTH-1:0]    wid_q;
  logic [PC_BITS-1:0]     pc_q;
  logic                   wb_q;
  logic [NR_BITS-1:0]     rd_q;
  logic [NUM_THREADS-1:0] tmask_q;   // full latched mask
  logic [DW-1:0]          data_q;    // full latched data
  logic [NUM_THREADS-1:0] out_tmask_q;
  logic [DW-1:0]          out_data_q;

  logic                   in_ready;
  logic                   in_fire;
  logic                   commit_fire;
  logic [NG-1:0]          grp_act;
  logic [NG-1:0]          init_pend;
  logic [NG-1:0]          cur_grp;
  logic [NG-1:0]          rest_pend;
  logic [NG-1:0]          src_pend;
  logic [NG-1:0]          src_cur;
  logic [NUM_THREADS-1:0] src_tmask;
  logic [DW-1:0]          src_data;
  logic [NUM_THREADS-1:0] beat_tmask;
  logic [DW-1:0]          beat_data;
  logic                   beat_eop;

  // Handshakes; commit_ready -> in_ready is the only combinational path.
  always_comb begin
    commit_fire = valid_q && bus.commit_ready;
    in_ready    = !reset && (state_q == StIdle || (commit_fire && eop_q));
    in_fire     = bus.in_valid && in_ready;
  end

  // Active lane groups of the incoming warp; an empty warp still sends group 0.
  always_comb begin
    grp_act = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      grp_act[g] = |bus.in_tmask[g*NUM_LANES +: NUM_LANES];
    end
    init_pend = (grp_act == '0) ? NG'(1) : grp_act;
  end

  // Next beat: from the new input on accept, otherwise from the remaining groups.
  always_comb begin
    cur_grp    = pend_q & (~pend_q + NG'(1));
    rest_pend  = pend_q & ~cur_grp;
    src_pend   = in_fire ? init_pend : rest_pend;
    src_tmask  = in_fire ? bus.in_tmask : tmask_q;
    src_data   = in_fire ? bus.in_data : data_q;
    src_cur    = src_pend & (~src_pend + NG'(1));
    beat_eop   = (src_pend & (src_pend - NG'(1))) == '0;
    beat_tmask = '0;
    beat_data  = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (src_cur[g]) begin
          beat_tmask[g*NUM_LANES + l]                 = src_tmask[g*NUM_LANES + l];
          beat_data[(g*NUM_LANES + l)*XLEN +: XLEN] = src_data[(g*NUM_LANES + l)*XLEN +: XLEN];
        end
      end
    end
  end

  // Packet FSM with registered beat outputs; accept wins over the eop retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else if (in_fire) begin
      state_q     <= StSend;
      pend_q      <= init_pend;
      valid_q     <= 1'b1;
      sop_q       <= 1'b1;
      eop_q       <= beat_eop;
      uuid_q      <= bus.in_uuid;
      wid_q       <= bus.in_wid;
      pc_q        <= bus.in_PC;
      wb_q        <= bus.in_wb;
      rd_q        <= bus.in_rd;
      tmask_q     <= bus.in_tmask;
      data_q      <= bus.in_data;
      out_tmask_q <= beat_tmask;
      out_data_q  <= beat_data;
    end else if (commit_fire) begin
      if (eop_q) begin
        state_q <= StIdle;
        pend_q  <= '0;
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end else begin
        pend_q      <= rest_pend;
        sop_q       <= 1'b0;
        eop_q       <= beat_eop;
        out_tmask_q <= beat_tmask;
        out_data_q  <= beat_data;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.commit_valid = valid_q;
  assign bus.commit_uuid  = uuid_q;
  assign bus.commit_wid   = wid_q;
  assign bus.commit_PC    = pc_q;
  assign bus.commit_wb    = wb_q;
  assign bus.commit_rd    = rd_q;
  assign bus.commit_tmask = out_tmask_q;
  assign bus.commit_data  = out_data_q;
  assign bus.commit_sop   = sop_q;
  assign bus.commit_eop   = eop_q;

`ifdef VX_COMMIT_PACKETIZER_PERF_EN
  logic [PERF_CTR_BITS-1:0] beats_q;
  logic [PERF_CTR_BITS-1:0] stalls_q;

  // Beat and stall counters, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (commit_fire) beats_q <= beats_q + PERF_CTR_BITS'(1);
      if (valid_q && !bus.commit_ready) stalls_q <= stalls_q + PERF_CTR_BITS'(1);
    end
  end

  assign perf_beats  = beats_q;
  assign perf_stalls = stalls_q;
`endif

endmodule
